// File: rtl/mac_tx_arbiter.sv
// Grants the single 32-bit MAC TX port to one packet generator at a time, round-robin, with IFG and sop timeout.
// Optional MAC_TX_ARB_PRIO_EN: requester 0 gets strict priority, the rest share round-robin.
module mac_tx_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int IFG_CYCLES = 2,
    parameter int TIMEOUT    = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [32*NUM_REQ-1:0]  req_data,
    input  logic [2*NUM_REQ-1:0]   req_mod,
    input  logic [NUM_REQ-1:0]     req_sop,
    input  logic [NUM_REQ-1:0]     req_eop,
    input  logic [NUM_REQ-1:0]     req_wren,
    output logic [NUM_REQ-1:0]     req_rdy,
    output logic [31:0]            Mac_tx_data,
    output logic [1:0]             Mac_tx_mod,
    output logic                   Mac_tx_sop,
    output logic                   Mac_tx_eop,
    output logic                   Mac_tx_wren,
    input  logic                   Mac_tx_rdy,
    output logic [2:0]             grant_id,
    output logic                   busy,
    output logic                   timeout_err
);
`ifdef MAC_TX_ARB_PRIO_EN
    localparam bit PRIO = 1'b1;
`else
    localparam bit PRIO = 1'b0;
`endif
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int TW = $clog2(TIMEOUT);
    localparam int GW = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
    localparam logic [GW-1:0] GAP_LAST = (IFG_CYCLES > 0) ? GW'(IFG_CYCLES - 1) : '0;

    typedef enum logic [1:0] {IDLE, WAIT_SOP, BUSY, GAP} state_t;

    state_t        state, state_nxt;
    logic [IW-1:0] owner, owner_nxt, rr_ptr, rr_ptr_nxt, winner, rr_next;
    logic [TW-1:0] tmo_cnt, tmo_cnt_nxt;
    logic [GW-1:0] gap_cnt, gap_cnt_nxt;
    logic          found, done;
    int            cand;

    logic [31:0]   own_data;
    logic [1:0]    own_mod;
    logic          own_sop, own_eop, own_wren, fwd;

    always_comb begin
        own_data = '0;
        own_mod  = '0;
        own_sop  = 1'b0;
        own_eop  = 1'b0;
        own_wren = 1'b0;
        req_rdy  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (owner == IW'(i)) begin
                own_data   = req_data[32*i +: 32];
                own_mod    = req_mod[2*i +: 2];
                own_sop    = req_sop[i];
                own_eop    = req_eop[i];
                own_wren   = req_wren[i];
                req_rdy[i] = Mac_tx_rdy & busy;
            end
        end
    end

    assign busy     = (state == WAIT_SOP) || (state == BUSY);
    assign grant_id = 3'(owner);

    // The sop word passes through in the same cycle it closes WAIT_SOP
    assign fwd         = (state == BUSY) || ((state == WAIT_SOP) && own_sop);
    assign Mac_tx_data = fwd ? own_data : '0;
    assign Mac_tx_mod  = fwd ? own_mod  : '0;
    assign Mac_tx_sop  = fwd & own_sop;
    assign Mac_tx_eop  = fwd & own_eop;
    assign Mac_tx_wren = fwd & own_wren;

    always_comb begin
        winner = rr_ptr;
        found  = 1'b0;
        cand   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = int'(rr_ptr) + k;
            if (cand >= NUM_REQ) cand = cand - NUM_REQ;
            if (!found && req[IW'(cand)] && (!PRIO || cand != 0)) begin
                winner = IW'(cand);
                found  = 1'b1;
            end
        end
        if (PRIO && req[0]) winner = '0;
    end

    assign rr_next = (int'(owner) == NUM_REQ - 1) ? '0 : owner + 1'b1;

    always_comb begin
        state_nxt   = state;
        owner_nxt   = owner;
        rr_ptr_nxt  = rr_ptr;
        tmo_cnt_nxt = tmo_cnt;
        gap_cnt_nxt = gap_cnt;
        timeout_err = 1'b0;
        done        = 1'b0;
        case (state)
            IDLE: begin
                if (|req) begin
                    owner_nxt   = winner;
                    tmo_cnt_nxt = '0;
                    state_nxt   = WAIT_SOP;
                end
            end
            WAIT_SOP: begin
                tmo_cnt_nxt = tmo_cnt + 1'b1;
                if (own_wren && own_sop) begin
                    if (own_eop) done = 1'b1;
                    else         state_nxt = BUSY;
                end else if (tmo_cnt == TMO_LAST) begin
                    timeout_err = 1'b1;
                    done        = 1'b1;
                end
            end
            BUSY: begin
                if (own_wren && own_eop) done = 1'b1;
            end
            GAP: begin
                if (gap_cnt == GAP_LAST) state_nxt = IDLE;
                else                     gap_cnt_nxt = gap_cnt + 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
        if (done) begin
            state_nxt   = (IFG_CYCLES == 0) ? IDLE : GAP;
            gap_cnt_nxt = '0;
            if (!PRIO || owner != '0) rr_ptr_nxt = rr_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            owner   <= '0;
            rr_ptr  <= '0;
            tmo_cnt <= '0;
            gap_cnt <= '0;
        end else begin
            state   <= state_nxt;
            owner   <= owner_nxt;
            rr_ptr  <= rr_ptr_nxt;
            tmo_cnt <= tmo_cnt_nxt;
            gap_cnt <= gap_cnt_nxt;
        end
    end
endmodule

// File: tb/tb_mac_tx_arbiter.sv
// Directed bench for mac_tx_arbiter: scoreboard of expected MAC words plus grant-order, gap, timeout and reset checks.
module tb_mac_tx_arbiter;
    localparam int N = 4, IFG = 2, TMO = 64;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [N-1:0]     req, req_sop, req_eop, req_wren, req_rdy;
    logic [32*N-1:0]  req_data;
    logic [2*N-1:0]   req_mod;
    logic [31:0]      Mac_tx_data;
    logic [1:0]       Mac_tx_mod;
    logic             Mac_tx_sop, Mac_tx_eop, Mac_tx_wren, Mac_tx_rdy;
    logic [2:0]       grant_id;
    logic             busy, timeout_err;
    logic [45:0]      all_outs;

    mac_tx_arbiter #(.NUM_REQ(N), .IFG_CYCLES(IFG), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data), .req_mod(req_mod),
        .req_sop(req_sop), .req_eop(req_eop), .req_wren(req_wren), .req_rdy(req_rdy),
        .Mac_tx_data(Mac_tx_data), .Mac_tx_mod(Mac_tx_mod), .Mac_tx_sop(Mac_tx_sop),
        .Mac_tx_eop(Mac_tx_eop), .Mac_tx_wren(Mac_tx_wren), .Mac_tx_rdy(Mac_tx_rdy),
        .grant_id(grant_id), .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    assign all_outs = {Mac_tx_data, Mac_tx_mod, Mac_tx_sop, Mac_tx_eop, Mac_tx_wren,
                       req_rdy, grant_id, busy, timeout_err};

    typedef struct packed {
        logic [2:0]  gid;
        logic [31:0] data;
        logic [1:0]  mod;
        logic        sop;
        logic        eop;
    } word_t;

    word_t exp_q[$];
    int    checks = 0, passes = 0, last_gap = 0, idle_run = 0, pkt_id = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    endtask

    task automatic set_lane(input int i, input logic [31:0] d, input logic [1:0] m,
                            input logic s, input logic e, input logic w);
        req_data[32*i +: 32] = d;
        req_mod[2*i +: 2]    = m;
        req_sop[i]           = s;
        req_eop[i]           = e;
        req_wren[i]          = w;
    endtask

    task automatic clear_lanes();
        req_data = '0;
        req_mod  = '0;
        req_sop  = '0;
        req_eop  = '0;
        req_wren = '0;
    endtask

    // Every word the MAC receives must be the next one the bench queued
    always @(negedge clk) begin
        word_t got, want;
        #3;
        if (rst_n && Mac_tx_wren) begin
            got = {grant_id, Mac_tx_data, Mac_tx_mod, Mac_tx_sop, Mac_tx_eop};
            if (Mac_tx_sop) last_gap = idle_run;
            idle_run = 0;
            check("wren_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                want = exp_q.pop_front();
                check("mac_word", 64'(got), 64'(want));
            end
        end else if (rst_n) begin
            idle_run++;
        end
    end

    // Waits for a grant among the requesting lanes, then streams nw words from the winner.
    task automatic serve(input int nw, input bit keep, input int stall_at, input int stall_len,
                         input int rst_at, output int who);
        int k, t, stalled, junk;
        bit first;
        logic [31:0] d;
        logic [1:0]  m;
        who = -1;
        t   = 0;
        while (who < 0 && t < 300) begin
            @(negedge clk);
            Mac_tx_rdy = 1'b1;
            #1;
            t++;
            for (int i = 0; i < N; i++) if (req_rdy[i] && who < 0) who = i;
        end
        check("grant_wait", 64'(who >= 0), 64'd1);
        if (who < 0) return;
        junk    = (who + 1) % N;
        k       = 0;
        stalled = 0;
        first   = 1'b1;
        while (k < nw && t < 900) begin
            if (!first) begin
                @(negedge clk);
                t++;
                if (k >= 1 && !keep) req[who] = 1'b0;
                Mac_tx_rdy = !(k == stall_at && stalled < stall_len);
                #1;
            end
            first = 1'b0;
            if (!Mac_tx_rdy) begin
                stalled++;
                set_lane(who, '0, '0, 1'b0, 1'b0, 1'b0);
                check("stall_req_rdy", 64'(req_rdy[who]), 64'd0);
            end else begin
                d = {8'(who), 8'(pkt_id), 16'(k)};
                m = (k == nw - 1) ? 2'(k) : 2'b00;
                set_lane(who, d, m, k == 0, k == nw - 1, 1'b1);
                exp_q.push_back({3'(who), d, m, k == 0, k == nw - 1});
                if (k == rst_at) begin
                    #1 rst_n = 1'b0;
                    #1;
                    check("reset_mid_packet", 64'(all_outs), 64'd0);
                    exp_q.delete();
                    clear_lanes();
                    req = '0;
                    repeat (2) @(negedge clk);
                    rst_n = 1'b1;
                    pkt_id++;
                    return;
                end
                k++;
            end
            set_lane(junk, 32'hBAD0_0000 | 32'(k), 2'b11, 1'b0, 1'b0, 1'b1);
        end
        check("packet_words", 64'(k), 64'(nw));
        @(negedge clk);
        #1;
        clear_lanes();
        if (!keep) req[who] = 1'b0;
        #1;
        check("post_eop_busy", 64'(busy), 64'd0);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        pkt_id++;
    endtask

    initial begin
        int who, n, cyc;
        rst_n      = 1'b0;
        req        = '0;
        Mac_tx_rdy = 1'b0;
        clear_lanes();
        repeat (3) @(negedge clk);
        req = '1;
        set_lane(1, 32'h1111_1111, 2'b01, 1'b1, 1'b1, 1'b1);
        Mac_tx_rdy = 1'b1;
        #1;
        check("reset_outputs", 64'(all_outs), 64'd0);
        req = '0;
        clear_lanes();
        @(negedge clk);
        rst_n = 1'b1;

        // Single IGMP-sized packet from requester 2
        req = 4'b0100;
        serve(14, 1'b0, -1, 0, -1, who);
        check("t1_owner", 64'(who), 64'd2);

        // Two requesters held: alternate, separated by the gap plus the arbitration cycle
        req = 4'b0011;
        for (int p = 0; p < 4; p++) begin
            serve(3, 1'b1, -1, 0, -1, who);
            check("t2_owner", 64'(who), 64'(p % 2));
            if (p > 0) check("t2_gap", 64'(last_gap), 64'(IFG + 1));
        end
        req = '0;

        // One-word sop+eop packet
        req = 4'b1000;
        serve(1, 1'b0, -1, 0, -1, who);
        check("single_owner", 64'(who), 64'd3);

        // Requester 1 granted but never sends sop; its stray words must be dropped
        req = 4'b0110;
        set_lane(1, 32'h5A5A_0001, 2'b00, 1'b0, 1'b0, 1'b1);
        cyc = 0;
        do begin
            @(negedge clk);
            #2;
            cyc++;
        end while (!busy && cyc < 50);
        check("t3_busy", 64'(busy), 64'd1);
        check("t3_owner", 64'(grant_id), 64'd1);
        n = 0;
        while (!timeout_err && n < 200) begin
            @(negedge clk);
            #2;
            n++;
        end
        check("t3_timeout_cycle", 64'(n), 64'(TMO - 1));
        @(negedge clk);
        #2;
        check("t3_err_pulse", 64'(timeout_err), 64'd0);
        check("t3_released", 64'(busy), 64'd0);
        clear_lanes();
        req = 4'b0100;
        serve(2, 1'b0, -1, 0, -1, who);
        check("t3_next_owner", 64'(who), 64'd2);

        // MAC back-pressure mid-packet
        req = 4'b0100;
        serve(8, 1'b0, 3, 5, -1, who);
        check("t4_owner", 64'(who), 64'd2);

        // Reset at word 6, then arbitration restarts from pointer 0
        req = 4'b1000;
        serve(10, 1'b0, -1, 0, 6, who);
        check("t5_trunc_owner", 64'(who), 64'd3);
        req = 4'b1010;
        serve(4, 1'b0, -1, 0, -1, who);
        check("t5_after_reset", 64'(who), 64'd1);
        serve(5, 1'b0, -1, 0, -1, who);
        check("t5_fresh_req3", 64'(who), 64'd3);

`ifdef MAC_TX_ARB_PRIO_EN
        req = 4'b1111;
        for (int p = 0; p < 3; p++) begin
            serve(2, 1'b1, -1, 0, -1, who);
            check("t6_prio0", 64'(who), 64'd0);
        end
        req = 4'b1110;
        for (int p = 0; p < 4; p++) begin
            serve(2, 1'b1, -1, 0, -1, who);
            check("t6_rr", 64'(who), 64'((p % 3) + 1));
        end
        req = '0;
`endif

        repeat (4) @(negedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
